keypad_entry: RTL and testbench
===============================

KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: number of consecutive identical valid samples required to accept a key.
REQ-003 Parameter BEEP_CYCLES, default 8: beep pulse length in clocks; used only when KEYPAD_BEEP_EN is defined.
REQ-004 Port clock, input, 1: system clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous active-high reset.
REQ-006 Port keypad, input, 10: raw one-hot key lines, bit n = digit n; asynchronous to clock.
REQ-007 Port mag_on, input, 1: magnetron running; keys are ignored while high.
REQ-008 Port entry_mins, output, 4: BCD minutes digit of the entered time.
REQ-009 Port entry_tens, output, 4: BCD seconds-tens digit.
REQ-010 Port entry_ones, output, 4: BCD seconds-ones digit.
REQ-011 Port load, output, 1: one-cycle pulse; entry_* are valid for the downstream timer load.
REQ-012 Port key_reject, output, 1: one-cycle pulse on a key refused by REQ-020.
REQ-013 Port beep, output, 1: key-accept beep; present only under KEYPAD_BEEP_EN.

Function
REQ-014 keypad SHALL pass through a two-flop synchronizer before any use; this adds 2 cycles of latency.
REQ-015 A sample is valid SHALL mean exactly one bit is set; zero bits or two or more bits count as no key.
REQ-016 The FSM SHALL have states IDLE, DEBOUNCE, ACCEPT and WAIT_RELEASE.
REQ-017 IDLE->DEBOUNCE on a valid sample with mag_on low; the debounce counter SHALL load 1.
REQ-018 In DEBOUNCE, a sample equal to the captured key SHALL increment the counter; any other sample SHALL return to IDLE; reaching DEBOUNCE_CYCLES SHALL go to ACCEPT.
REQ-019 In ACCEPT (one cycle), the key SHALL shift in: mins<=tens, tens<=ones, ones<=key; the old mins is discarded; load SHALL pulse in the same cycle the registers update.
REQ-020 If the current entry_ones>5 in ACCEPT, the shift SHALL NOT occur; key_reject SHALL pulse and load SHALL stay low.
REQ-021 ACCEPT SHALL always go to WAIT_RELEASE; WAIT_RELEASE->IDLE only after DEBOUNCE_CYCLES consecutive all-zero samples, so holding a key yields one entry.
REQ-022 mag_on high SHALL force DEBOUNCE or ACCEPT to WAIT_RELEASE without a shift or pulse; entry_* SHALL hold.
REQ-023 The debounce counter SHALL saturate at DEBOUNCE_CYCLES and never wrap; its width SHALL be $clog2(DEBOUNCE_CYCLES+1).
REQ-024 load and key_reject SHALL never be high in the same cycle.

Reset
REQ-025 On reset: FSM=IDLE, entry_mins/tens/ones=0, load=0, key_reject=0, beep=0, counters=0, synchronizer flops=0.
REQ-026 Reset asserted mid-debounce or in ACCEPT SHALL win over every other update in that cycle; no load pulse SHALL be emitted.

Configuration
REQ-027 Macro KEYPAD_BEEP_EN defined: port beep exists and goes high for BEEP_CYCLES clocks starting with each load pulse; a new load during a beep SHALL restart the count.
REQ-028 Macro KEYPAD_BEEP_EN undefined: the beep port and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, a 4-bit BCD digit typedef and the constant MAX_SEC_TENS=5.
REQ-030 The synchronizer, one-hot validity check and debounce counter SHALL form the sub-module key_debouncer, which outputs the stable key code and a one-cycle press strobe.

Verification
REQ-031 Press key 1, then 2, then 3, each held 10 cycles, with gaps of 10 cycles -> entry = 1,2,3, with exactly 3 load pulses.
REQ-032 A 2-cycle glitch on key 7 with DEBOUNCE_CYCLES=4 -> no load and entry unchanged.
REQ-033 With entry_ones=7, press key 4 -> one key_reject pulse and entry unchanged.
REQ-034 Keys 3 and 5 pressed together for 20 cycles -> no load; after release, key 5 alone -> ones=5.
REQ-035 mag_on=1 while key 9 is held for 20 cycles -> no load and entry unchanged.
REQ-036 Reset during DEBOUNCE, then with KEYPAD_BEEP_EN: key 0 -> entry 000, then accept -> beep high for exactly 8 cycles.

Source files
------------

// File: rtl/keypad_entry_pkg.sv
// Shared types for the keypad entry block: FSM states, BCD digit, one-hot helpers.
package keypad_entry_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        ACCEPT,
        WAIT_RELEASE
    } kp_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t MAX_SEC_TENS = 4'd5;

    function automatic logic is_one_hot(input logic [9:0] v);
        return (v != '0) && ((v & (v - 10'd1)) == '0);
    endfunction

    function automatic bcd_t onehot_to_bcd(input logic [9:0] v);
        bcd_t code;
        code = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (v[i]) code = bcd_t'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Keypad-side and timer-load signals of keypad_entry; beep only exists under KEYPAD_BEEP_EN.
interface keypad_entry_if;
    import keypad_entry_pkg::*;

    logic [9:0] keypad;
    logic       mag_on;
    bcd_t       entry_mins;
    bcd_t       entry_tens;
    bcd_t       entry_ones;
    logic       load;
    logic       key_reject;
`ifdef KEYPAD_BEEP_EN
    logic       beep;
`endif

    modport master (
        output keypad, mag_on,
        input  entry_mins, entry_tens, entry_ones, load, key_reject
`ifdef KEYPAD_BEEP_EN
        , beep
`endif
    );

    modport slave (
        input  keypad, mag_on,
        output entry_mins, entry_tens, entry_ones, load, key_reject
`ifdef KEYPAD_BEEP_EN
        , beep
`endif
    );

endinterface

// File: rtl/key_debouncer.sv
// Synchronizes raw key lines, qualifies one-hot samples and debounces press/release;
// emits the stable key code with a one-cycle press strobe (high while in ACCEPT).
module key_debouncer
    import keypad_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] keypad,
    input  logic       mag_on,
    output bcd_t       key_code,
    output logic       press
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [9:0]    sync_q1;
    logic [9:0]    sync_q2;
    logic [9:0]    key_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_inc;
    logic          sample_valid;
    kp_state_t     state_q;

    assign sample_valid = is_one_hot(sync_q2);
    assign cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q1  <= '0;
            sync_q2  <= '0;
            key_q    <= '0;
            key_code <= '0;
            cnt_q    <= '0;
            press    <= 1'b0;
            state_q  <= IDLE;
        end else begin
            sync_q1 <= keypad;
            sync_q2 <= sync_q1;
            press   <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (sample_valid && !mag_on) begin
                        key_q    <= sync_q2;
                        key_code <= onehot_to_bcd(sync_q2);
                        cnt_q    <= CNT_ONE;
                        if (CNT_ONE == CNT_MAX) begin
                            state_q <= ACCEPT;
                            press   <= 1'b1;
                        end else begin
                            state_q <= DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (mag_on) begin
                        cnt_q   <= '0;
                        state_q <= WAIT_RELEASE;
                    end else if (sync_q2 == key_q) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            state_q <= ACCEPT;
                            press   <= 1'b1;
                        end
                    end else begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                ACCEPT: begin
                    cnt_q   <= '0;
                    state_q <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    // any non-zero sample, including multi-key, restarts the release count
                    if (sync_q2 == '0) begin
                        if (cnt_inc == CNT_MAX) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// Microwave time-entry keypad: shifts debounced digits into a 3-digit BCD entry.
// Optional key-accept beep is built when KEYPAD_BEEP_EN is defined.
module keypad_entry
    import keypad_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
`ifdef KEYPAD_BEEP_EN
    , parameter int unsigned BEEP_CYCLES = 8
`endif
) (
    input  logic          clock,
    input  logic          reset,
    keypad_entry_if.slave bus
);
    bcd_t key_code;
    logic press;
    logic do_shift;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debouncer (
        .clock    (clock),
        .reset    (reset),
        .keypad   (bus.keypad),
        .mag_on   (bus.mag_on),
        .key_code (key_code),
        .press    (press)
    );

    // a seconds-ones digit above 5 cannot become the seconds-tens digit
    assign do_shift = press && !bus.mag_on && (bus.entry_ones <= MAX_SEC_TENS);

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.entry_mins <= '0;
            bus.entry_tens <= '0;
            bus.entry_ones <= '0;
            bus.load       <= 1'b0;
            bus.key_reject <= 1'b0;
        end else begin
            bus.load       <= do_shift;
            bus.key_reject <= press && !bus.mag_on && (bus.entry_ones > MAX_SEC_TENS);
            if (do_shift) begin
                bus.entry_mins <= bus.entry_tens;
                bus.entry_tens <= bus.entry_ones;
                bus.entry_ones <= key_code;
            end
        end
    end

`ifdef KEYPAD_BEEP_EN
    localparam int unsigned BW = $clog2(BEEP_CYCLES + 1);

    logic [BW-1:0] beep_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            beep_cnt <= '0;
            bus.beep <= 1'b0;
        end else if (do_shift) begin
            beep_cnt <= BW'(BEEP_CYCLES - 1);
            bus.beep <= 1'b1;
        end else if (beep_cnt != '0) begin
            beep_cnt <= beep_cnt - 1'b1;
        end else begin
            bus.beep <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: directed scenarios then random presses
// checked against a press-level reference model.
module tb_keypad_entry;
    import keypad_entry_pkg::*;

    localparam int unsigned N = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    keypad_entry_if bus();

    keypad_entry #(
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    int load_total = 0;
    int rej_total  = 0;
    int both_total = 0;
    int beep_total = 0;

    always @(negedge clock) begin
        if (bus.load === 1'b1) load_total++;
        if (bus.key_reject === 1'b1) rej_total++;
        if (bus.load === 1'b1 && bus.key_reject === 1'b1) both_total++;
`ifdef KEYPAD_BEEP_EN
        if (bus.beep === 1'b1) beep_total++;
`endif
    end

    // reference entry, index 0 = minutes, 2 = seconds-ones
    int m_dig[3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_entry(input string tag);
        check({tag, ".mins"}, 32'(bus.entry_mins), 32'(m_dig[0]));
        check({tag, ".tens"}, 32'(bus.entry_tens), 32'(m_dig[1]));
        check({tag, ".ones"}, 32'(bus.entry_ones), 32'(m_dig[2]));
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        bus.keypad = '0;
        bus.mag_on = 1'b0;
        tick(2);
        reset = 1'b0;
        m_dig = '{0, 0, 0};
    endtask

    // one press window: mask held for 'hold' cycles, then 'gap' idle cycles
    task automatic press(input string tag, input logic [9:0] mask, input int hold,
                         input int gap, input logic mag);
        int l0, r0, b0, be0;
        int exp_load, exp_rej, key;
        l0  = load_total;
        r0  = rej_total;
        b0  = both_total;
        be0 = beep_total;
        bus.mag_on = mag;
        bus.keypad = mask;
        tick(hold);
        bus.keypad = '0;
        tick(gap);
        bus.mag_on = 1'b0;

        exp_load = 0;
        exp_rej  = 0;
        if ($countones(mask) == 1 && hold >= int'(N) && !mag) begin
            key = 0;
            for (int i = 0; i < 10; i++) if (mask[i]) key = i;
            if (m_dig[2] > 5) begin
                exp_rej = 1;
            end else begin
                exp_load = 1;
                m_dig[0] = m_dig[1];
                m_dig[1] = m_dig[2];
                m_dig[2] = key;
            end
        end

        check({tag, ".loads"}, 32'(load_total - l0), 32'(exp_load));
        check({tag, ".rejects"}, 32'(rej_total - r0), 32'(exp_rej));
        check({tag, ".both"}, 32'(both_total - b0), 32'd0);
`ifdef KEYPAD_BEEP_EN
        check({tag, ".beep"}, 32'(beep_total - be0), 32'(exp_load * 8));
`endif
        check_entry(tag);
    endtask

    initial begin
        int l0;
        logic [9:0] mask;
        int a, b;

        bus.keypad = '0;
        bus.mag_on = 1'b0;
        tick(1);
        do_reset();
        check("rst.load", 32'(bus.load), 32'd0);
        check("rst.reject", 32'(bus.key_reject), 32'd0);
`ifdef KEYPAD_BEEP_EN
        check("rst.beep", 32'(bus.beep), 32'd0);
`endif
        check_entry("rst");

        l0 = load_total;
        press("k1", 10'b1 << 1, 10, 10, 1'b0);
        press("k2", 10'b1 << 2, 10, 10, 1'b0);
        press("k3", 10'b1 << 3, 10, 10, 1'b0);
        check("seq123.loads", 32'(load_total - l0), 32'd3);

        press("glitch7", 10'b1 << 7, 2, 12, 1'b0);
        press("k7", 10'b1 << 7, 10, 12, 1'b0);
        press("rej4", 10'b1 << 4, 10, 12, 1'b0);

        do_reset();
        press("multi35", (10'b1 << 3) | (10'b1 << 5), 20, 12, 1'b0);
        press("k5", 10'b1 << 5, 10, 12, 1'b0);
        press("mag9", 10'b1 << 9, 20, 12, 1'b1);

        // reset lands while the FSM is mid-debounce on key 2
        l0 = load_total;
        bus.keypad = 10'b1 << 2;
        tick(5);
        reset      = 1'b1;
        bus.keypad = '0;
        tick(1);
        reset = 1'b0;
        m_dig = '{0, 0, 0};
        tick(10);
        check("rstdeb.loads", 32'(load_total - l0), 32'd0);
        check_entry("rstdeb");
        press("k0", 10'b1 << 0, 10, 14, 1'b0);

        for (int n = 0; n < 30; n++) begin
            if (m_dig[2] > 5 && $urandom_range(0, 1) == 1) do_reset();
            if ($urandom_range(0, 4) == 0) begin
                a = int'($urandom_range(0, 9));
                b = (a + 1 + int'($urandom_range(0, 8))) % 10;
                mask = (10'b1 << a) | (10'b1 << b);
            end else begin
                mask = 10'b1 << $urandom_range(0, 9);
            end
            press("rnd", mask, int'($urandom_range(1, 12)), int'($urandom_range(12, 16)),
                  ($urandom_range(0, 6) == 0) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
